// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch front end.
//   fetch_entry_t : one instruction-queue entry {instr, pc}
//   fetch_state_t : fetch controller states
//   FETCH_ADDR_W / INS_COUNT_DEFAULT / RESET_PC_DEFAULT : default geometry
package fetch_unit_pkg;

    localparam int          FETCH_ADDR_W      = 32;
    localparam int          INS_COUNT_DEFAULT = 4;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'hBFC0_0000;

    typedef struct packed {
        logic [31:0]             instr;
        logic [FETCH_ADDR_W-1:0] pc;
    } fetch_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DELIVER,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch unit's external handshakes: I-cache request/response,
// instruction-queue insert port and the backend redirect/flush pair.
//   master : the fetch unit side
//   slave  : the environment side (I-cache, queue, backend)
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int INS_COUNT    = INS_COUNT_DEFAULT,
    parameter int ADDR_W       = FETCH_ADDR_W,
    parameter int INSCOUNTLOG2 = $clog2(INS_COUNT)
) ();

    // I-cache request / response
    logic                    ic_req_valid;
    logic                    ic_req_ready;
    logic [ADDR_W-1:0]       ic_req_addr;
    logic                    ic_resp_valid;
    logic [INS_COUNT*32-1:0] ic_resp_data;

    // Instruction queue insert port
    logic                    iq_full;
    logic                    ins_enable;
    logic [INSCOUNTLOG2-1:0] new_count;
    fetch_entry_t            new_elements [INS_COUNT];

    // Backend redirect and queue flush
    logic                    redirect;
    logic [ADDR_W-1:0]       redirect_pc;
    logic                    flush;

    modport master (
        output ic_req_valid, ic_req_addr,
        input  ic_req_ready, ic_resp_valid, ic_resp_data,
        input  iq_full,
        output ins_enable, new_count, new_elements,
        input  redirect, redirect_pc,
        output flush
    );

    modport slave (
        input  ic_req_valid, ic_req_addr,
        output ic_req_ready, ic_resp_valid, ic_resp_data,
        output iq_full,
        input  ins_enable, new_count, new_elements,
        output redirect, redirect_pc,
        input  flush
    );

endinterface

// File: rtl/fetch_align.sv
// Packs one I-cache block into instruction-queue entries, starting at the
// word the fetch PC points to. Purely combinational.
//   block_base   : block-aligned address of the response
//   off          : word offset of the fetch PC inside the block
//   ic_resp_data : INS_COUNT words, word i at [32i+31:32i]
//   entries      : slot i holds word (off+i); slots past the block end are zero
//   new_count    : number of valid slots minus one
module fetch_align
    import fetch_unit_pkg::*;
#(
    parameter int INS_COUNT    = INS_COUNT_DEFAULT,
    parameter int ADDR_W       = FETCH_ADDR_W,
    parameter int INSCOUNTLOG2 = $clog2(INS_COUNT)
) (
    input  logic [ADDR_W-1:0]       block_base,
    input  logic [INSCOUNTLOG2-1:0] off,
    input  logic [INS_COUNT*32-1:0] ic_resp_data,
    output fetch_entry_t            entries [INS_COUNT],
    output logic [INSCOUNTLOG2-1:0] new_count
);

    // One extra bit so off+i can be compared against INS_COUNT without wrapping
    localparam int IW = INSCOUNTLOG2 + 1;

    logic [31:0] words [INS_COUNT];

    genvar gi;
    generate
        for (gi = 0; gi < INS_COUNT; gi++) begin : g_slot
            logic [IW-1:0]     idx;
            logic              in_range;
            logic [ADDR_W-1:0] slot_pc;

            assign words[gi] = ic_resp_data[32*gi +: 32];
            assign idx       = IW'(off) + IW'(gi);
            assign in_range  = (idx < IW'(INS_COUNT));
            assign slot_pc   = block_base + (ADDR_W'(idx) << 2);

            assign entries[gi] = in_range ? {words[idx[INSCOUNTLOG2-1:0]], slot_pc}
                                          : '0;
        end
    endgenerate

    // INS_COUNT is a power of two, so this never underflows
    assign new_count = INSCOUNTLOG2'(INS_COUNT - 1) - off;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage in front of the instruction queue. Holds the fetch PC, issues
// one block-aligned I-cache request at a time, packs the response into queue
// entries and pushes them once the queue has room. Backend redirects reload
// the PC, flush the queue and discard any response still in flight.
//   clock, reset_n : clock and asynchronous active-low reset
//   bus            : fetch_unit_if.master (I-cache, queue and redirect ports)
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                INS_COUNT    = INS_COUNT_DEFAULT,
    parameter int                ADDR_W       = FETCH_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter int                INSCOUNTLOG2 = $clog2(INS_COUNT)
) (
    input  logic        clock,
    input  logic        reset_n,
    fetch_unit_if.master bus
);

    localparam int LOW_BITS = INSCOUNTLOG2 + 2;

    fetch_state_t            state_reg, state_next;
    logic [ADDR_W-1:0]       fetch_pc_reg, fetch_pc_next;
    fetch_entry_t            hold_entries_reg [INS_COUNT];
    logic [INSCOUNTLOG2-1:0] hold_count_reg;

    logic [ADDR_W-1:0]       block_base;
    logic [INSCOUNTLOG2-1:0] off;
    fetch_entry_t            align_entries [INS_COUNT];
    logic [INSCOUNTLOG2-1:0] align_count;

    logic                    req_valid;
    logic                    ins_en;
    logic                    hold_load;
    logic                    hold_clear;

    // The byte offset within a word never affects fetch
    logic                    unused_pc_bits;
    assign unused_pc_bits = ^fetch_pc_reg[1:0];

    assign block_base = {fetch_pc_reg[ADDR_W-1:LOW_BITS], LOW_BITS'(0)};
    assign off        = fetch_pc_reg[INSCOUNTLOG2+1:2];

    fetch_align #(
        .INS_COUNT    (INS_COUNT),
        .ADDR_W       (ADDR_W),
        .INSCOUNTLOG2 (INSCOUNTLOG2)
    ) u_align (
        .block_base   (block_base),
        .off          (off),
        .ic_resp_data (bus.ic_resp_data),
        .entries      (align_entries),
        .new_count    (align_count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            fetch_pc_reg   <= RESET_PC;
            hold_count_reg <= '0;
            for (int i = 0; i < INS_COUNT; i++) begin
                hold_entries_reg[i] <= '0;
            end
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            if (hold_load) begin
                hold_count_reg <= align_count;
                for (int i = 0; i < INS_COUNT; i++) begin
                    hold_entries_reg[i] <= align_entries[i];
                end
            end else if (hold_clear) begin
                hold_count_reg <= '0;
                for (int i = 0; i < INS_COUNT; i++) begin
                    hold_entries_reg[i] <= '0;
                end
            end
        end
    end

    // Redirect wins over every other event outside IDLE. A request is never
    // issued and nothing is pushed in a redirect cycle.
    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        req_valid     = 1'b0;
        ins_en        = 1'b0;
        hold_load     = 1'b0;
        hold_clear    = 1'b0;

        case (state_reg)
            IDLE: begin
                state_next = REQ;
            end

            REQ: begin
                req_valid = ~bus.redirect;
                if (bus.redirect) begin
                    fetch_pc_next = bus.redirect_pc;
                end else if (bus.ic_req_ready) begin
                    state_next = WAIT;
                end
            end

            WAIT: begin
                if (bus.redirect) begin
                    fetch_pc_next = bus.redirect_pc;
                    // A response arriving with the redirect is the stale one;
                    // otherwise it is still owed and must be drained.
                    state_next    = bus.ic_resp_valid ? REQ : DRAIN;
                end else if (bus.ic_resp_valid) begin
                    hold_load  = 1'b1;
                    state_next = DELIVER;
                end
            end

            DELIVER: begin
                ins_en = ~bus.iq_full & ~bus.redirect;
                if (bus.redirect) begin
                    fetch_pc_next = bus.redirect_pc;
                    hold_clear    = 1'b1;
                    state_next    = REQ;
                end else if (ins_en) begin
                    // Continue at the next sequential block, offset 0
                    fetch_pc_next = block_base + ADDR_W'(INS_COUNT * 4);
                    state_next    = REQ;
                end
            end

            DRAIN: begin
                if (bus.redirect) begin
                    fetch_pc_next = bus.redirect_pc;
                end
                if (bus.ic_resp_valid) begin
                    state_next = REQ;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.ic_req_valid = req_valid;
    assign bus.ic_req_addr  = block_base;
    assign bus.ins_enable   = ins_en;
    assign bus.new_count    = hold_count_reg;
    assign bus.new_elements = hold_entries_reg;
    assign bus.flush        = bus.redirect & reset_n;

endmodule
